// File: rtl/verinject_pkg.sv
// verinject_pkg
//   Constants and types shared by the injection sequencer and every verinject
//   injector. The injector bus reserves the two highest codes; all other
//   values on the bus are fault indices.
package verinject_pkg;

  localparam logic [31:0] VERINJECT_STATE_IDLE  = 32'hFFFF_FFFF;
  localparam logic [31:0] VERINJECT_STATE_CLEAR = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_CLEAR = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] index;
  } sched_entry_t;

  // A fault index that collides with a bus control code cannot be scheduled.
  function automatic logic is_reserved_index(input logic [31:0] idx);
    return idx >= VERINJECT_STATE_CLEAR;
  endfunction

endpackage

// File: rtl/verinject_sched_fifo.sv
// verinject_sched_fifo
//   Schedule storage: SCHED_DEPTH x 64-bit (cycle, index) entries.
//   Entries are never removed by reading; the read pointer only walks forward
//   and can be rewound to 0 so a run can be replayed.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   push_i/entry_i    : append entry at the write pointer (ignored when full)
//   pop_i             : advance the read pointer past the head
//   rewind_i          : read from entry 0 this cycle (combines with pop_i)
//   flush_i           : empty the schedule (wins over push)
//   head_o            : entry at the (possibly rewound) read pointer
//   full_o, empty_o   : write-side status
//   exhausted_o       : every stored entry has been read this run
module verinject_sched_fifo
  import verinject_pkg::*;
#(
  parameter int SCHED_DEPTH      = 8,
  parameter int SCHED_DEPTH_LOG2 = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  sched_entry_t entry_i,
  input  logic         pop_i,
  input  logic         rewind_i,
  input  logic         flush_i,
  output sched_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         exhausted_o
);

  localparam logic [SCHED_DEPTH_LOG2:0] PTR_ONE = 1;
  localparam logic [SCHED_DEPTH_LOG2:0] PTR_MAX = SCHED_DEPTH;

  sched_entry_t mem_q [SCHED_DEPTH];
  // The write pointer doubles as the entry count: nothing is ever dequeued.
  logic [SCHED_DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [SCHED_DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [SCHED_DEPTH_LOG2:0] rd_base;
  logic                      do_push;

  assign rd_base     = rewind_i ? '0 : rd_ptr_q;
  assign head_o      = mem_q[rd_base[SCHED_DEPTH_LOG2-1:0]];
  assign full_o      = (wr_ptr_q == PTR_MAX);
  assign empty_o     = (wr_ptr_q == '0);
  assign exhausted_o = (rd_ptr_q == wr_ptr_q);
  assign do_push     = push_i && !full_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      rd_ptr_d = (pop_i && (rd_base != wr_ptr_q)) ? rd_base + PTR_ONE : rd_base;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[SCHED_DEPTH_LOG2-1:0]] <= entry_i;
  end

endmodule

// File: rtl/verinject_injection_sequencer.sv
// verinject_injection_sequencer
//   Drives the global injector bus. Replays a pre-loaded schedule of
//   (cycle, fault index) pairs after start, one index per clock at most,
//   and issues the injector FIFO-clear code on request.
// Ports:
//   clock, reset                     : clock and synchronous active-high reset
//   load_valid/load_ready            : schedule load handshake; an entry moves
//                                      on a rising edge where both are high.
//                                      load_ready never depends on load_valid.
//   load_cycle, load_index           : entry payload
//   start, clear_faults, flush       : run control, sampled every edge
//   verinject__injector_state        : registered injector bus
//   busy, done                       : registered RUN|CLEAR / DONE flags
//   load_error                       : sticky, reserved index offered
//   cycle_count, issued_count        : run cycle and entries issued this run
//   dbg_state_o                      : current sequencer state
module verinject_injection_sequencer
  import verinject_pkg::*;
#(
  parameter int SCHED_DEPTH      = 8,
  parameter int SCHED_DEPTH_LOG2 = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [31:0]               load_cycle,
  input  logic [31:0]               load_index,
  input  logic                      start,
  input  logic                      clear_faults,
  input  logic                      flush,
  output logic [31:0]               verinject__injector_state,
  output logic                      busy,
  output logic                      done,
  output logic                      load_error,
  output logic [31:0]               cycle_count,
  output logic [SCHED_DEPTH_LOG2:0] issued_count,
  output seq_state_e                dbg_state_o
);

  localparam logic [SCHED_DEPTH_LOG2:0] CNT_ONE = 1;

  seq_state_e                state_q, state_d;
  logic [31:0]               bus_q, bus_d;
  logic [31:0]               cycle_q, cycle_d;
  logic [SCHED_DEPTH_LOG2:0] issued_q, issued_d;
  logic                      err_q, err_d;
  logic                      busy_q, done_q;

  logic         push, pop, rewind, fifo_flush;
  logic         full, empty, exhausted;
  sched_entry_t head;
  logic         start_ok, load_fire;

  verinject_sched_fifo #(
    .SCHED_DEPTH      (SCHED_DEPTH),
    .SCHED_DEPTH_LOG2 (SCHED_DEPTH_LOG2)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .entry_i     ({load_cycle, load_index}),
    .pop_i       (pop),
    .rewind_i    (rewind),
    .flush_i     (fifo_flush),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .exhausted_o (exhausted)
  );

  assign start_ok   = start && !empty;
  assign load_ready = (state_q == SEQ_IDLE) && !full && !start && !flush && !clear_faults;
  assign load_fire  = load_valid && load_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear_faults outranks every other request.
  always_comb begin
    state_d = state_q;
    if (clear_faults) begin
      state_d = SEQ_CLEAR;
    end else begin
      unique case (state_q)
        SEQ_IDLE, SEQ_DONE: begin
          if (flush)         state_d = SEQ_IDLE;
          else if (start_ok) state_d = SEQ_RUN;
        end
        SEQ_RUN:   if (exhausted) state_d = SEQ_DONE;
        SEQ_CLEAR: state_d = SEQ_IDLE;
        default:   state_d = SEQ_IDLE;
      endcase
    end
  end

  // Datapath next values. The bus is loaded from next-state values, so an
  // entry due at cycle C appears in the same period cycle_count reads C.
  always_comb begin
    bus_d      = VERINJECT_STATE_IDLE;
    cycle_d    = cycle_q;
    issued_d   = issued_q;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    rewind     = 1'b0;
    fifo_flush = 1'b0;

    if (load_fire) begin
      if (is_reserved_index(load_index)) err_d = 1'b1;
      else                               push  = 1'b1;
    end

    if (!clear_faults) begin
      unique case (state_q)
        SEQ_IDLE, SEQ_DONE: begin
          if (flush) begin
            fifo_flush = 1'b1;
          end else if (start_ok) begin
            // Head is read from entry 0 while the pointer rewinds.
            rewind   = 1'b1;
            cycle_d  = '0;
            issued_d = '0;
            if (head.cycle == '0) begin
              pop      = 1'b1;
              bus_d    = head.index;
              issued_d = CNT_ONE;
            end
          end
        end
        SEQ_RUN: begin
          cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
          // Late or colliding entries are still due; they slip one clock each.
          if (!exhausted && (head.cycle <= cycle_d)) begin
            pop      = 1'b1;
            bus_d    = head.index;
            issued_d = issued_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end

    if (state_d == SEQ_CLEAR) bus_d = VERINJECT_STATE_CLEAR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_q    <= VERINJECT_STATE_IDLE;
      cycle_q  <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      cycle_q  <= cycle_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      busy_q   <= (state_d == SEQ_RUN) || (state_d == SEQ_CLEAR);
      done_q   <= (state_d == SEQ_DONE);
    end
  end

  assign verinject__injector_state = bus_q;
  assign cycle_count               = cycle_q;
  assign issued_count              = issued_q;
  assign load_error                = err_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign dbg_state_o               = state_q;

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Testbench for verinject_injection_sequencer: directed vectors, a schedule
// model that derives each entry's issue slot from its cycle and predecessor,
// a per-cycle compare process, and literal spot checks.
module tb_verinject_injection_sequencer;
  import verinject_pkg::*;

  localparam int          DEPTH     = 8;
  localparam int          LOG2      = 3;
  localparam logic [31:0] BUS_IDLE  = 32'hFFFF_FFFF;
  localparam logic [31:0] BUS_CLEAR = 32'hFFFF_FFFE;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_cycle = '0;
  logic [31:0] load_index = '0;
  logic        start = 1'b0;
  logic        clear_faults = 1'b0;
  logic        flush = 1'b0;
  logic        load_ready, busy, done, load_error;
  logic [31:0] bus, cycle_count;
  logic [LOG2:0] issued_count;
  seq_state_e  dbg_state;

  always #5 clock = ~clock;

  verinject_injection_sequencer #(
    .SCHED_DEPTH      (DEPTH),
    .SCHED_DEPTH_LOG2 (LOG2)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .load_valid                (load_valid),
    .load_ready                (load_ready),
    .load_cycle                (load_cycle),
    .load_index                (load_index),
    .start                     (start),
    .clear_faults              (clear_faults),
    .flush                     (flush),
    .verinject__injector_state (bus),
    .busy                      (busy),
    .done                      (done),
    .load_error                (load_error),
    .cycle_count               (cycle_count),
    .issued_count              (issued_count),
    .dbg_state_o               (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- schedule model ----------------
  // Modes: 0 idle, 1 run, 2 clear, 3 done.
  logic [31:0] m_cyc[$];
  logic [31:0] m_idx[$];
  logic [31:0] exp_q[$];   // expected bus value for each remaining run period
  int          m_mode   = 0;
  logic [31:0] m_k      = '0;
  logic [31:0] m_bus    = BUS_IDLE;
  logic        m_err    = 1'b0;
  int          m_issued = 0;

  // Entry i goes out at max(cycle_i, slot_{i-1}+1); gaps are idle.
  task automatic model_begin_run();
    longint t_prev;
    longint t;
    exp_q.delete();
    t_prev = -1;
    foreach (m_cyc[i]) begin
      t = (longint'(m_cyc[i]) > t_prev) ? longint'(m_cyc[i]) : t_prev + 1;
      while (longint'(exp_q.size()) < t) exp_q.push_back(BUS_IDLE);
      exp_q.push_back(m_idx[i]);
      t_prev = t;
    end
    m_k      = '0;
    m_issued = 0;
    m_mode   = 1;
    m_bus    = exp_q.pop_front();
    if (m_bus != BUS_IDLE) m_issued++;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_cyc.delete(); m_idx.delete(); exp_q.delete();
      m_err = 1'b0; m_k = '0; m_issued = 0; m_bus = BUS_IDLE;
    end else if (clear_faults) begin
      m_mode = 2;
      m_bus  = BUS_CLEAR;
    end else begin
      case (m_mode)
        0, 3: begin
          m_bus = BUS_IDLE;
          if (flush) begin
            m_cyc.delete(); m_idx.delete(); m_mode = 0;
          end else if (start && m_cyc.size() > 0) begin
            model_begin_run();
          end else if (m_mode == 0 && load_valid && !start && m_cyc.size() < DEPTH) begin
            if (load_index >= BUS_CLEAR) m_err = 1'b1;
            else begin
              m_cyc.push_back(load_cycle);
              m_idx.push_back(load_index);
            end
          end
        end
        1: begin
          m_k = (m_k == 32'hFFFF_FFFF) ? m_k : m_k + 32'd1;
          if (exp_q.size() > 0) begin
            m_bus = exp_q.pop_front();
            if (m_bus != BUS_IDLE) m_issued++;
          end else begin
            m_mode = 3;
            m_bus  = BUS_IDLE;
          end
        end
        default: begin
          m_mode = 0;
          m_bus  = BUS_IDLE;
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en) begin
      check32("bus",          bus,                 m_bus);
      check32("busy",         32'(busy),           32'(m_mode == 1 || m_mode == 2));
      check32("done",         32'(done),           32'(m_mode == 3));
      check32("load_error",   32'(load_error),     32'(m_err));
      check32("cycle_count",  cycle_count,         m_k);
      check32("issued_count", 32'(issued_count),   32'(m_issued));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_entry(input logic [31:0] c, input logic [31:0] idx);
    @(negedge clock);
    load_valid = 1'b1; load_cycle = c; load_index = idx;
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  // which: 0 start, 1 flush, 2 clear_faults
  task automatic pulse(input int which);
    @(negedge clock);
    if (which == 0) start = 1'b1;
    else if (which == 1) flush = 1'b1;
    else clear_faults = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0; clear_faults = 1'b0;
  endtask

  logic [31:0] log_bus [64];

  // Record the bus per run cycle until done rises (bounded).
  task automatic watch_run(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) log_bus[i] = BUS_IDLE;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #1;
      if (cycle_count < 32'd64) log_bus[cycle_count[5:0]] = bus;
      if (done) begin seen = 1'b1; break; end
    end
    check32({name, "_done_reached"}, 32'(seen), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    bit found;
    bit saw_300;
    repeat (2) @(posedge clock);
    chk_en = 1'b1;
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock); #1;
    check32("rst_bus",    bus,                BUS_IDLE);
    check32("rst_state",  32'(dbg_state),     32'(SEQ_IDLE));
    check32("rst_cycle",  cycle_count,        32'd0);
    check32("rst_issued", 32'(issued_count),  32'd0);
    check32("rst_ready",  32'(load_ready),    32'd1);

    // (3,100),(5,200),(5,201): 201 slips to cycle 6, DONE at 7
    load_entry(32'd3, 32'd100);
    load_entry(32'd5, 32'd200);
    load_entry(32'd5, 32'd201);
    pulse(0);
    watch_run(30, "t1");
    check32("t1_c2",     log_bus[2], BUS_IDLE);
    check32("t1_c3",     log_bus[3], 32'd100);
    check32("t1_c4",     log_bus[4], BUS_IDLE);
    check32("t1_c5",     log_bus[5], 32'd200);
    check32("t1_c6",     log_bus[6], 32'd201);
    check32("t1_cycle",  cycle_count, 32'd7);
    check32("t1_issued", 32'(issued_count), 32'd3);

    // (0,7): first RUN period, DONE next; replay identical
    pulse(1);
    load_entry(32'd0, 32'd7);
    for (int r = 0; r < 2; r++) begin
      pulse(0);
      watch_run(10, "t2");
      check32("t2_c0",    log_bus[0], 32'd7);
      check32("t2_cycle", cycle_count, 32'd1);
    end

    // Fill the schedule; ninth entry refused, run issues exactly eight
    pulse(1);
    for (int i = 0; i < DEPTH; i++) load_entry(32'd10 + 32'(i), 32'd1000 + 32'(i));
    @(negedge clock);
    load_valid = 1'b1; load_cycle = 32'd11; load_index = 32'd9999;
    #1 check32("full_ready0", 32'(load_ready), 32'd0);
    @(negedge clock); #1;
    check32("full_ready1", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    pulse(0);
    watch_run(40, "t3");
    check32("t3_c10",    log_bus[10], 32'd1000);
    check32("t3_c17",    log_bus[17], 32'd1007);
    check32("t3_issued", 32'(issued_count), 32'd8);
    check32("t3_cycle",  cycle_count, 32'd18);
    pulse(1);
    @(negedge clock); #1;
    check32("flush_ready", 32'(load_ready), 32'd1);
    check32("flush_state", 32'(dbg_state), 32'(SEQ_IDLE));

    // Reserved index: consumed, flagged, never issued
    load_entry(32'd2, 32'd50);
    @(negedge clock);
    load_valid = 1'b1; load_cycle = 32'd3; load_index = BUS_CLEAR;
    #1 check32("err_ready", 32'(load_ready), 32'd1);
    @(posedge clock); #1;
    load_valid = 1'b0;
    load_entry(32'd4, 32'd60);
    @(negedge clock); #1;
    check32("err_flag", 32'(load_error), 32'd1);
    pulse(0);
    watch_run(20, "t4");
    check32("t4_c2",     log_bus[2], 32'd50);
    check32("t4_c3",     log_bus[3], BUS_IDLE);
    check32("t4_c4",     log_bus[4], 32'd60);
    check32("t4_issued", 32'(issued_count), 32'd2);

    // clear_faults at cycle 2 with entry at 4 pending
    pulse(1);
    load_entry(32'd4, 32'd300);
    pulse(0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (busy && cycle_count == 32'd2) begin found = 1'b1; break; end
    end
    check32("clr_reach_c2", 32'(found), 32'd1);
    clear_faults = 1'b1;
    @(posedge clock); #1;
    clear_faults = 1'b0;
    @(negedge clock); #1;
    check32("clr_bus",   bus, BUS_CLEAR);
    check32("clr_state", 32'(dbg_state), 32'(SEQ_CLEAR));
    @(negedge clock); #1;
    check32("clr_bus_after",   bus, BUS_IDLE);
    check32("clr_state_after", 32'(dbg_state), 32'(SEQ_IDLE));
    saw_300 = 1'b0;
    repeat (6) begin
      @(negedge clock); #1;
      if (bus == 32'd300) saw_300 = 1'b1;
    end
    check32("clr_no_300", 32'(saw_300), 32'd0);

    // Reset while an index is on the bus
    pulse(1);
    load_entry(32'd1, 32'd11);
    load_entry(32'd2, 32'd22);
    load_entry(32'd5, BUS_IDLE);
    pulse(0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (bus == 32'd11) begin found = 1'b1; break; end
    end
    check32("rst_mid_reach", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    check32("rst_mid_bus",   bus, BUS_IDLE);
    check32("rst_mid_state", 32'(dbg_state), 32'(SEQ_IDLE));
    check32("rst_mid_err",   32'(load_error), 32'd0);
    pulse(0);
    @(negedge clock); #1;
    check32("rst_mid_empty_start", 32'(dbg_state), 32'(SEQ_IDLE));

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
